// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants for the UART framed-command parser.
// Frame layout is {SYNC, CMD, DATA, CSUM}.
package uart_cmd_parser_pkg;

  localparam logic [2:0] ST_SYNC = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_CSUM = 3'd3;
  localparam logic [2:0] ST_OUT  = 3'd4;

  localparam logic [7:0] DEF_SYNC_BYTE   = 8'hA5;
  localparam logic [7:0] DEF_CMD_ATTEMPT = 8'h01;
  localparam logic [7:0] DEF_CMD_PING    = 8'h02;

  localparam int DEF_TIMEOUT_CYC = 2000;
  localparam int DEF_TMO_W       = 16;

  // XOR of the three leading frame bytes.
  function automatic logic [7:0] frame_csum(
    input logic [7:0] s,
    input logic [7:0] c,
    input logic [7:0] d
  );
    return s ^ c ^ d;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_sat_cnt8.sv
// Saturating 8-bit event counter.
// Sticks at 8'hFF instead of wrapping.
module sat_cnt8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] cnt
);

  // count enabled events, holding at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en && (cnt != 8'hFF)) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Framed-command parser between UART RX stream and the attempt FSM.
// Validates {SYNC,CMD,DATA,CSUM} frames, forwards ATTEMPT data bytes.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE,
  parameter logic [7:0] CMD_ATTEMPT = DEF_CMD_ATTEMPT,
  parameter logic [7:0] CMD_PING    = DEF_CMD_PING,
  parameter int         TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int         TMO_W       = DEF_TMO_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       ping_pulse,
  output logic       err_pulse,
  output logic [7:0] frame_cnt,
  output logic [7:0] err_cnt,
  output logic       busy
);

  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(TIMEOUT_CYC - 1);

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [7:0]       cmd_q;
  logic [7:0]       cmd_d;
  logic [7:0]       data_q;
  logic [7:0]       data_d;
  logic [TMO_W-1:0] tmr_q;
  logic [TMO_W-1:0] tmr_d;
  logic             ping_q;
  logic             ping_d;
  logic             err_q;
  logic             err_d;
  logic             frame_inc;
  logic             acc;
  logic             in_frame;
  logic             tmo;
  logic             csum_ok;

  assign s_axis_tready = (state_q != ST_OUT);
  assign acc           = s_axis_tvalid && s_axis_tready;

  assign in_frame = (state_q == ST_CMD)
                 || (state_q == ST_DATA)
                 || (state_q == ST_CSUM);

  // idle budget used up on this cycle with nothing arriving
  assign tmo = in_frame && !acc && (tmr_q == TMO_LAST);

  assign csum_ok =
    (s_axis_tdata == frame_csum(SYNC_BYTE, cmd_q, data_q));

  assign m_axis_tvalid = (state_q == ST_OUT);
  assign m_axis_tdata  = m_axis_tvalid ? data_q : 8'h00;
  assign busy          = (state_q != ST_SYNC);
  assign ping_pulse    = ping_q;
  assign err_pulse     = err_q;

  // next-state, latch and decision logic
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    tmr_d     = '0;
    ping_d    = 1'b0;
    err_d     = 1'b0;
    frame_inc = 1'b0;

    if (in_frame && !acc) begin
      tmr_d = tmr_q + 1'b1;
    end

    case (state_q)
      ST_SYNC: begin
        if (acc && (s_axis_tdata == SYNC_BYTE)) begin
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (acc && (s_axis_tdata != SYNC_BYTE)) begin
          cmd_d   = s_axis_tdata;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (acc) begin
          data_d  = s_axis_tdata;
          state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (acc) begin
          unique case (1'b1)
            csum_ok && (cmd_q == CMD_ATTEMPT): begin
              state_d   = ST_OUT;
              frame_inc = 1'b1;
            end
            csum_ok && (cmd_q == CMD_PING): begin
              state_d   = ST_SYNC;
              ping_d    = 1'b1;
              frame_inc = 1'b1;
            end
            default: begin
              state_d = ST_SYNC;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      ST_OUT: begin
        if (m_axis_tready) begin
          state_d = ST_SYNC;
        end
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase

    if (tmo) begin
      state_d = ST_SYNC;
      err_d   = 1'b1;
      tmr_d   = '0;
    end
  end

  // register state, latched bytes, timer and pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SYNC;
      cmd_q   <= '0;
      data_q  <= '0;
      tmr_q   <= '0;
      ping_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      tmr_q   <= tmr_d;
      ping_q  <= ping_d;
      err_q   <= err_d;
    end
  end

  sat_cnt8 u_frame_cnt (
    .clk (clk),
    .rst (rst),
    .en  (frame_inc),
    .cnt (frame_cnt)
  );

  sat_cnt8 u_err_cnt (
    .clk (clk),
    .rst (rst),
    .en  (err_d),
    .cnt (err_cnt)
  );

endmodule
